// File: rtl/utf8_stream_decoder.sv
// UTF-8 byte-stream sequence assembler: collects 1..MAX_BYTES bytes, validates
// lead/continuation/range, and emits raw bytes plus the decoded code point.
module utf8_stream_decoder #(
  parameter int MAX_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter bit CHECK_RANGE    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [31:0] seq_out,
  output logic [2:0]  seq_len,
  output logic [20:0] codepoint,
  output logic        is_ascii,
  output logic        out_valid,
  output logic        err,
  output logic [2:0]  err_code,
  output logic        busy
);

  localparam logic [2:0] E_LEAD    = 3'd1;
  localparam logic [2:0] E_CONT    = 3'd2;
  localparam logic [2:0] E_TIMEOUT = 3'd3;
  localparam logic [2:0] E_RANGE   = 3'd4;
  // Idle-count value at which the next idle cycle expires the sequence.
  localparam logic [31:0] TO_LIM = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t      state, nstate;
  logic [2:0]  len_q, n_len, rem_q, n_rem;
  logic [31:0] buf_q, n_buf, timer_q, n_timer;
  logic [20:0] acc_q, n_acc;

  logic        emit, fire;
  logic [2:0]  fire_code, e_len, l;
  logic [31:0] e_seq;
  logic [20:0] e_cp;
  logic        do_lead;
  int          sh;

  // Sequence length announced by a lead byte; 0 marks an unusable lead.
  function automatic logic [2:0] lead_len(input logic [7:0] b);
    logic [2:0] n;
    casez (b)
      8'b0???????: n = 3'd1;
      8'b110?????: n = 3'd2;
      8'b1110????: n = 3'd3;
      8'b11110???: n = 3'd4;
      default:     n = 3'd0;
    endcase
    if (int'(n) > MAX_BYTES) n = 3'd0;
    return n;
  endfunction

  // Overlong, surrogate and upper-bound screening of a completed sequence.
  function automatic logic range_ok(input logic [20:0] cp, input logic [2:0] n);
    logic ok;
    ok = 1'b1;
    if (CHECK_RANGE) begin
      if (cp > 21'h10FFFF) ok = 1'b0;
      if (cp >= 21'h00D800 && cp <= 21'h00DFFF) ok = 1'b0;
      case (n)
        3'd2:    if (cp < 21'h000080) ok = 1'b0;
        3'd3:    if (cp < 21'h000800) ok = 1'b0;
        3'd4:    if (cp < 21'h010000) ok = 1'b0;
        default: ;
      endcase
    end
    return ok;
  endfunction

  // Next-state, accumulation, error and emit decisions for this cycle's byte.
  always_comb begin
    nstate    = state;
    n_len     = len_q;
    n_rem     = rem_q;
    n_buf     = buf_q;
    n_acc     = acc_q;
    n_timer   = timer_q;
    emit      = 1'b0;
    fire      = 1'b0;
    fire_code = 3'd0;
    e_seq     = 32'd0;
    e_len     = 3'd0;
    e_cp      = 21'd0;
    do_lead   = 1'b0;
    sh        = 0;
    l         = 3'd0;

    if (state == IDLE) begin
      n_timer = 32'd0;
      do_lead = byte_valid;
    end else if (byte_valid) begin
      n_timer = 32'd0;
      if (byte_in[7:6] == 2'b10) begin
        sh    = 8 * (3 - int'(len_q) + int'(rem_q));
        n_buf = buf_q | (32'(byte_in) << sh);
        n_acc = {acc_q[14:0], byte_in[5:0]};
        n_rem = rem_q - 3'd1;
        if (rem_q == 3'd1) begin
          nstate = IDLE;
          if (range_ok(n_acc, len_q)) begin
            emit  = 1'b1;
            e_seq = n_buf;
            e_len = len_q;
            e_cp  = n_acc;
          end else begin
            fire      = 1'b1;
            fire_code = E_RANGE;
          end
        end
      end else begin
        // Partial sequence is dropped; the byte gets a second life as a lead.
        fire      = 1'b1;
        fire_code = E_CONT;
        nstate    = IDLE;
        do_lead   = 1'b1;
      end
    end else if (TIMEOUT_CYCLES != 0) begin
      if (timer_q == TO_LIM) begin
        fire      = 1'b1;
        fire_code = E_TIMEOUT;
        nstate    = IDLE;
        n_timer   = 32'd0;
      end else begin
        n_timer = timer_q + 32'd1;
      end
    end

    if (do_lead) begin
      l = lead_len(byte_in);
      if (l == 3'd0) begin
        // A discarded partial takes reporting priority over the bad lead.
        if (!fire) begin
          fire      = 1'b1;
          fire_code = E_LEAD;
        end
      end else if (l == 3'd1) begin
        emit  = 1'b1;
        e_seq = {byte_in, 24'd0};
        e_len = 3'd1;
        e_cp  = {14'd0, byte_in[6:0]};
      end else begin
        nstate  = COLLECT;
        n_len   = l;
        n_rem   = l - 3'd1;
        n_buf   = {byte_in, 24'd0};
        n_timer = 32'd0;
        case (l)
          3'd2:    n_acc = {16'd0, byte_in[4:0]};
          3'd3:    n_acc = {17'd0, byte_in[3:0]};
          default: n_acc = {18'd0, byte_in[2:0]};
        endcase
      end
    end
  end

  // State and collection registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      len_q   <= 3'd0;
      rem_q   <= 3'd0;
      buf_q   <= 32'd0;
      acc_q   <= 21'd0;
      timer_q <= 32'd0;
    end else begin
      state   <= nstate;
      len_q   <= n_len;
      rem_q   <= n_rem;
      buf_q   <= n_buf;
      acc_q   <= n_acc;
      timer_q <= n_timer;
    end
  end

  // Registered outputs: data holds between pulses, err_code holds between errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_out   <= 32'd0;
      seq_len   <= 3'd0;
      codepoint <= 21'd0;
      is_ascii  <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      err_code  <= 3'd0;
    end else begin
      out_valid <= emit;
      err       <= fire;
      if (emit) begin
        seq_out   <= e_seq;
        seq_len   <= e_len;
        codepoint <= e_cp;
        is_ascii  <= (e_len == 3'd1);
      end
      if (fire) err_code <= fire_code;
    end
  end

  assign busy = (state == COLLECT);

endmodule

// File: tb/tb_utf8_stream_decoder.sv
// Directed-vector bench for utf8_stream_decoder: a table of byte/expectation
// records plus hand sequences for timeout, reset and MAX_BYTES=3 behaviour.
module tb_utf8_stream_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;

  logic [31:0] seq_out, seq_out3;
  logic [2:0]  seq_len, seq_len3, err_code, err_code3;
  logic [20:0] codepoint, codepoint3;
  logic        is_ascii, out_valid, err, busy;
  logic        is_ascii3, out_valid3, err3, busy3;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  utf8_stream_decoder #(.MAX_BYTES(4), .TIMEOUT_CYCLES(16), .CHECK_RANGE(1'b1)) dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .seq_out(seq_out), .seq_len(seq_len), .codepoint(codepoint), .is_ascii(is_ascii),
    .out_valid(out_valid), .err(err), .err_code(err_code), .busy(busy)
  );

  utf8_stream_decoder #(.MAX_BYTES(3), .TIMEOUT_CYCLES(16), .CHECK_RANGE(1'b1)) dut3 (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .seq_out(seq_out3), .seq_len(seq_len3), .codepoint(codepoint3), .is_ascii(is_ascii3),
    .out_valid(out_valid3), .err(err3), .err_code(err_code3), .busy(busy3)
  );

  typedef struct {
    logic [7:0]  b;
    int          gap;
    logic        ov;
    logic        er;
    logic [2:0]  ec;
    logic        bz;
    logic [20:0] cp;
    logic [31:0] seq;
    logic [2:0]  len;
    logic        asc;
  } vec_t;

  vec_t tv[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Called at a negedge; strobes one byte across the next posedge and
  // returns at the following negedge, where the resulting pulse is visible.
  task automatic send(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    tv[0]  = '{8'h41, 0,  1'b1, 1'b0, 3'd0, 1'b0, 21'h41,    32'h41000000, 3'd1, 1'b1};
    tv[1]  = '{8'hE0, 0,  1'b0, 1'b0, 3'd0, 1'b1, 21'h41,    32'h41000000, 3'd1, 1'b1};
    tv[2]  = '{8'hB8, 10, 1'b0, 1'b0, 3'd0, 1'b1, 21'h41,    32'h41000000, 3'd1, 1'b1};
    tv[3]  = '{8'h81, 10, 1'b1, 1'b0, 3'd0, 1'b0, 21'h00E01, 32'hE0B88100, 3'd3, 1'b0};
    tv[4]  = '{8'hF0, 0,  1'b0, 1'b0, 3'd0, 1'b1, 21'h00E01, 32'hE0B88100, 3'd3, 1'b0};
    tv[5]  = '{8'h9F, 0,  1'b0, 1'b0, 3'd0, 1'b1, 21'h00E01, 32'hE0B88100, 3'd3, 1'b0};
    tv[6]  = '{8'h98, 0,  1'b0, 1'b0, 3'd0, 1'b1, 21'h00E01, 32'hE0B88100, 3'd3, 1'b0};
    tv[7]  = '{8'h80, 0,  1'b1, 1'b0, 3'd0, 1'b0, 21'h1F600, 32'hF09F9880, 3'd4, 1'b0};
    tv[8]  = '{8'hE0, 0,  1'b0, 1'b0, 3'd0, 1'b1, 21'h1F600, 32'hF09F9880, 3'd4, 1'b0};
    tv[9]  = '{8'h41, 0,  1'b1, 1'b1, 3'd2, 1'b0, 21'h41,    32'h41000000, 3'd1, 1'b1};
    tv[10] = '{8'hC0, 0,  1'b0, 1'b0, 3'd2, 1'b1, 21'h41,    32'h41000000, 3'd1, 1'b1};
    tv[11] = '{8'h80, 0,  1'b0, 1'b1, 3'd4, 1'b0, 21'h41,    32'h41000000, 3'd1, 1'b1};
    tv[12] = '{8'hED, 0,  1'b0, 1'b0, 3'd4, 1'b1, 21'h41,    32'h41000000, 3'd1, 1'b1};
    tv[13] = '{8'hA0, 0,  1'b0, 1'b0, 3'd4, 1'b1, 21'h41,    32'h41000000, 3'd1, 1'b1};
    tv[14] = '{8'h80, 0,  1'b0, 1'b1, 3'd4, 1'b0, 21'h41,    32'h41000000, 3'd1, 1'b1};
    tv[15] = '{8'h80, 0,  1'b0, 1'b1, 3'd1, 1'b0, 21'h41,    32'h41000000, 3'd1, 1'b1};
    tv[16] = '{8'hF8, 0,  1'b0, 1'b1, 3'd1, 1'b0, 21'h41,    32'h41000000, 3'd1, 1'b1};
    tv[17] = '{8'hC2, 0,  1'b0, 1'b0, 3'd1, 1'b1, 21'h41,    32'h41000000, 3'd1, 1'b1};
    tv[18] = '{8'hA9, 0,  1'b1, 1'b0, 3'd1, 1'b0, 21'h000A9, 32'hC2A90000, 3'd2, 1'b0};
    tv[19] = '{8'hF4, 0,  1'b0, 1'b0, 3'd1, 1'b1, 21'h000A9, 32'hC2A90000, 3'd2, 1'b0};
    tv[20] = '{8'h90, 0,  1'b0, 1'b0, 3'd1, 1'b1, 21'h000A9, 32'hC2A90000, 3'd2, 1'b0};
    tv[21] = '{8'h80, 0,  1'b0, 1'b0, 3'd1, 1'b1, 21'h000A9, 32'hC2A90000, 3'd2, 1'b0};
    tv[22] = '{8'h80, 0,  1'b0, 1'b1, 3'd4, 1'b0, 21'h000A9, 32'hC2A90000, 3'd2, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_seq", seq_out, 32'd0);
    chk("rst_len", 32'(seq_len), 32'd0);
    chk("rst_cp", 32'(codepoint), 32'd0);
    chk("rst_flags", {28'd0, is_ascii, out_valid, err, busy}, 32'd0);
    chk("rst_ec", 32'(err_code), 32'd0);

    // Table-driven main stream
    for (int i = 0; i < 23; i++) begin
      for (int g = 0; g < tv[i].gap; g++) begin
        @(negedge clk);
        chk($sformatf("gap%0d_quiet", i), {30'd0, out_valid, err}, 32'd0);
        chk($sformatf("gap%0d_busy", i), 32'(busy), 32'(tv[i-1].bz));
      end
      send(tv[i].b);
      chk($sformatf("v%0d_ov", i),  32'(out_valid), 32'(tv[i].ov));
      chk($sformatf("v%0d_err", i), 32'(err),       32'(tv[i].er));
      chk($sformatf("v%0d_ec", i),  32'(err_code),  32'(tv[i].ec));
      chk($sformatf("v%0d_busy", i), 32'(busy),     32'(tv[i].bz));
      chk($sformatf("v%0d_cp", i),  32'(codepoint), 32'(tv[i].cp));
      chk($sformatf("v%0d_seq", i), seq_out,        tv[i].seq);
      chk($sformatf("v%0d_len", i), 32'(seq_len),   32'(tv[i].len));
      chk($sformatf("v%0d_asc", i), 32'(is_ascii),  32'(tv[i].asc));
    end

    // Timeout: E0 then silence expires on the 16th idle cycle
    do_reset();
    send(8'hE0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d", k), {30'd0, busy, err}, 32'd2);
    end
    @(negedge clk);
    chk("to_err", 32'(err), 32'd1);
    chk("to_ec", 32'(err_code), 32'd3);
    chk("to_busy", 32'(busy), 32'd0);

    // Continuation arriving on the 16th idle cycle beats the timeout
    do_reset();
    send(8'hE0);
    repeat (15) @(negedge clk);
    send(8'hB8);
    chk("edge_err", 32'(err), 32'd0);
    chk("edge_busy", 32'(busy), 32'd1);
    send(8'h81);
    chk("edge_ov", 32'(out_valid), 32'd1);
    chk("edge_cp", 32'(codepoint), 32'h00E01);

    // Reset mid-sequence drops silently
    send(8'hE0);
    send(8'hB8);
    do_reset();
    chk("mrst_err", 32'(err), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_cp", 32'(codepoint), 32'd0);
    chk("mrst_seq", seq_out, 32'd0);
    send(8'h41);
    chk("mrst_after_err", 32'(err), 32'd0);
    chk("mrst_after_ov", 32'(out_valid), 32'd1);
    chk("mrst_after_cp", 32'(codepoint), 32'h41);

    // MAX_BYTES=3: a 4-byte lead and its tail are all invalid leads
    do_reset();
    send(8'hF0);
    chk("m3_lead_err", 32'(err3), 32'd1);
    chk("m3_lead_ec", 32'(err_code3), 32'd1);
    chk("m3_lead_busy", 32'(busy3), 32'd0);
    chk("m4_lead_busy", 32'(busy), 32'd1);
    send(8'h9F);
    chk("m3_9f", {29'd0, err3, err_code3[1:0]}, 32'd5);
    send(8'h98);
    chk("m3_98", {29'd0, err3, err_code3[1:0]}, 32'd5);
    send(8'h80);
    chk("m3_80", {29'd0, err3, err_code3[1:0]}, 32'd5);
    chk("m3_80_ec", 32'(err_code3), 32'd1);
    chk("m4_cp", 32'(codepoint), 32'h1F600);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
